// File: rtl/e_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// mduOp encodings, FSM state codes and the HI/LO pair type.
package e_mdu_pkg;

    localparam int MDU_OP_W = 4;
    localparam int CNT_W    = 8;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
    import e_mdu_pkg::*;

    logic [MDU_OP_W-1:0] mduOp;
    logic [31:0]         A;
    logic [31:0]         B;
    logic                start;
    logic                busy;
    logic [31:0]         mduOut;

    modport master (output mduOp, A, B, input start, busy, mduOut);
    modport slave  (input mduOp, A, B, output start, busy, mduOut);
endinterface

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide datapath producing the pending {HI,LO}.
// A zero divisor yields the current HI/LO so the commit leaves them unchanged.
module mdu_arith
    import e_mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output hilo_t               pend
);

    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic        sgn_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] qm_s;
    logic [31:0] rm_s;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign sprod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod_s = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        sgn_s   = (mdu_op == MDU_DIV);
        neg_a_s = sgn_s & a[31];
        neg_b_s = sgn_s & b[31];
        mag_a_s = mag32(a, neg_a_s);
        mag_b_s = mag32(b, neg_b_s);
        if (b != 32'd0) begin
            qm_s = mag_a_s / mag_b_s;
            rm_s = mag_a_s % mag_b_s;
        end else begin
            qm_s = 32'd0;
            rm_s = 32'd0;
        end
        q_s = mag32(qm_s, neg_a_s ^ neg_b_s);
        r_s = mag32(rm_s, neg_a_s);
    end

    // Result select per operation.
    always_comb begin
        pend = '{hi: hi, lo: lo};
        case (mdu_op)
            MDU_MULT:  pend = sprod_s;
            MDU_MULTU: pend = uprod_s;
            MDU_DIV, MDU_DIVU: begin
                if (b != 32'd0) begin
                    pend = '{hi: r_s, lo: q_s};
                end else begin
                    pend = '{hi: hi, lo: lo};
                end
            end
            default:   pend = '{hi: hi, lo: lo};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: owns HI/LO, computes the result at issue, and holds it
// pending for MULT_CYCLES/DIV_CYCLES of busy before committing.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      phi_r;
    logic [31:0]      plo_r;
    logic             busy_r;

    hilo_t            pend_s;
    logic             is_md_s;
    logic             is_mult_s;
    logic             start_s;
    logic [CNT_W-1:0] load_cnt_s;
    logic [31:0]      mdu_out_s;

    mdu_arith u_arith (
        .mdu_op (bus.mduOp),
        .a      (bus.A),
        .b      (bus.B),
        .hi     (hi_r),
        .lo     (lo_r),
        .pend   (pend_s)
    );

    // Classify the requested operation and pick its latency.
    always_comb begin
        is_md_s   = 1'b0;
        is_mult_s = 1'b0;
        case (bus.mduOp)
            MDU_MULT, MDU_MULTU: begin
                is_md_s   = 1'b1;
                is_mult_s = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                is_md_s   = 1'b1;
                is_mult_s = 1'b0;
            end
            default: begin
                is_md_s   = 1'b0;
                is_mult_s = 1'b0;
            end
        endcase
        if (is_mult_s) begin
            load_cnt_s = CNT_W'(MULT_CYCLES);
        end else begin
            load_cnt_s = CNT_W'(DIV_CYCLES);
        end
        start_s = is_md_s & ~busy_r;
    end

    // Zero-latency read port for committed HI/LO.
    always_comb begin
        mdu_out_s = 32'd0;
        case (bus.mduOp)
            MDU_MFHI: mdu_out_s = hi_r;
            MDU_MFLO: mdu_out_s = lo_r;
            default:  mdu_out_s = 32'd0;
        endcase
    end

    assign bus.start  = start_s;
    assign bus.busy   = busy_r;
    assign bus.mduOut = mdu_out_s;

    // FSM, latency counter, pending and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            phi_r   <= 32'd0;
            plo_r   <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        phi_r   <= pend_s.hi;
                        plo_r   <= pend_s.lo;
                        cnt_r   <= load_cnt_s;
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else if (bus.mduOp == MDU_MTHI) begin
                        hi_r <= bus.A;
                    end else if (bus.mduOp == MDU_MTLO) begin
                        lo_r <= bus.A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Commit on the last busy cycle; <= also recovers from a zero latency setting.
                    if (cnt_r <= CNT_W'(1)) begin
                        hi_r    <= phi_r;
                        lo_r    <= plo_r;
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO pairs are queued at issue and
// popped when the unit drops busy and the result is read with mfhi/mflo.
module tb_e_mdu;
    import e_mdu_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [31:0] m_hi;
    logic [31:0] ra;
    logic [31:0] rb;
    longint      sp;
    logic [63:0] p64;

    always #5 clk = ~clk;

    e_mdu_if mif ();

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mif.mduOp = op;
        mif.A     = a;
        mif.B     = b;
        #1;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            step(MDU_MFHI, 32'd0, 32'd0);
            chk({tag, "_idle"}, {31'd0, mif.busy}, 32'd0);
            chk({tag, "_hi"}, mif.mduOut, e.hi);
            step(MDU_MFLO, 32'd0, 32'd0);
            chk({tag, "_lo"}, mif.mduOut, e.lo);
            m_hi = e.hi;
        end
    endtask

    // Issue one mult/div, inject intr_op on the second busy cycle, then check the result.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [3:0] intr_op,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        step(op, a, b);
        chk({tag, "_start"}, {31'd0, mif.start}, 32'd1);
        chk({tag, "_notbusy"}, {31'd0, mif.busy}, 32'd0);
        sb.push_back({exp_hi, exp_lo});
        for (int i = 1; i <= n; i++) begin
            if (i == 2) begin
                step(intr_op, 32'h0000DEAD, 32'd3);
                if (intr_op == MDU_MFHI) begin
                    chk({tag, "_early"}, mif.mduOut, m_hi);
                end
            end else begin
                step(MDU_NONE, 32'd0, 32'd0);
            end
            chk({tag, "_busy"}, {31'd0, mif.busy}, 32'd1);
            chk({tag, "_nostart"}, {31'd0, mif.start}, 32'd0);
        end
        check_result(tag);
    endtask

    initial begin
        reset     = 1'b1;
        mif.mduOp = MDU_NONE;
        mif.A     = 32'd0;
        mif.B     = 32'd0;
        m_hi      = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        step(MDU_MFHI, 32'd0, 32'd0);
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_hi", mif.mduOut, 32'd0);
        step(MDU_MFLO, 32'd0, 32'd0);
        chk("rst_lo", mif.mduOut, 32'd0);
        step(4'd12, 32'd1, 32'd1);
        chk("op12_start", {31'd0, mif.start}, 32'd0);
        chk("op12_out", mif.mduOut, 32'd0);

        run_md("mult", MDU_MULT, 32'hFFFFFFFF, 32'd2, 5, MDU_MFHI, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 5, MDU_MFHI, 32'h00000001, 32'hFFFFFFFE);
        run_md("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, MDU_MFHI, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu", MDU_DIVU, 32'd7, 32'd2, 10, MDU_MFHI, 32'd1, 32'd3);
        run_md("div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 10, MDU_MFHI, 32'd1, 32'hFFFFFFFD);
        run_md("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, MDU_MFHI, 32'd0, 32'h80000000);

        ra = $urandom;
        rb = $urandom;
        sp = longint'($signed(ra)) * longint'($signed(rb));
        p64 = sp;
        run_md("mult_rnd", MDU_MULT, ra, rb, 5, MDU_MFHI, p64[63:32], p64[31:0]);
        p64 = {32'd0, ra} * {32'd0, rb};
        run_md("multu_rnd", MDU_MULTU, ra, rb, 5, MDU_MFHI, p64[63:32], p64[31:0]);

        step(MDU_MFHI, 32'd0, 32'd0);
        chk("mthi_old", mif.mduOut, m_hi);
        step(MDU_MTHI, 32'h12345678, 32'd0);
        chk("mthi_out0", mif.mduOut, 32'd0);
        step(MDU_MFHI, 32'd0, 32'd0);
        chk("mthi_new", mif.mduOut, 32'h12345678);

        step(MDU_MTHI, 32'hAAAA0000, 32'd0);
        step(MDU_MTLO, 32'h00005555, 32'd0);
        m_hi = 32'hAAAA0000;
        run_md("div0_mtlo", MDU_DIV, 32'd100, 32'd0, 10, MDU_MTLO, 32'hAAAA0000, 32'h00005555);
        run_md("divu0_mult", MDU_DIVU, 32'd100, 32'd0, 10, MDU_MULT, 32'hAAAA0000, 32'h00005555);

        step(MDU_MULT, 32'd3, 32'd5);
        chk("rstmid_start", {31'd0, mif.start}, 32'd1);
        step(MDU_NONE, 32'd0, 32'd0);
        step(MDU_NONE, 32'd0, 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        mif.mduOp = MDU_NONE;
        #1;
        chk("rstmid_busy3", {31'd0, mif.busy}, 32'd1);
        @(negedge clk);
        reset     = 1'b0;
        mif.mduOp = MDU_MFHI;
        #1;
        chk("rstmid_busy", {31'd0, mif.busy}, 32'd0);
        chk("rstmid_hi", mif.mduOut, 32'd0);
        step(MDU_MFLO, 32'd0, 32'd0);
        chk("rstmid_lo", mif.mduOut, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(MDU_MFLO, 32'd0, 32'd0);
            chk("rstmid_nolate", mif.mduOut, 32'd0);
            chk("rstmid_idle", {31'd0, mif.busy}, 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
